// File: rtl/tt10_result_tx.sv
// Serialises result words as 8E1-style frames: start 0, 8 data bits LSB first,
// even parity, stop 1. Each bit lasts CLKS_PER_BIT cycles; the line is registered.
module tt10_result_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        parity, parity_n;
  logic [7:0]  count_n;
  logic        tx_n;
  logic        bit_end;

  assign data_ready = (state == IDLE);
  assign busy       = ~data_ready;
  assign bit_end    = (timer == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      frame_count <= '0;
      tx_out      <= 1'b1;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      parity      <= parity_n;
      frame_count <= count_n;
      tx_out      <= tx_n;
    end
  end

  // Next-state logic; tx_n is derived from the *next* state so the registered
  // line shows each bit in exactly the cycles its state occupies.
  always_comb begin
    state_n   = state;
    timer_n   = timer + 16'd1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    parity_n  = parity;
    count_n   = frame_count;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (data_valid) begin
          shreg_n  = data_in;
          parity_n = ^data_in;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = PARITY;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          timer_n = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          count_n = frame_count + 8'd1;
          state_n = IDLE;
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule
